// File: rtl/sm_debug_ctrl.sv
// Debug run-control for a simple core: halt/run/single-step, one hardware
// breakpoint on the word-address pc, and an executed-instruction counter.
module sm_debug_ctrl #(
  parameter bit RUN_ON_RESET = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_data,
  input  logic [31:0]      pc,
  output logic             cpu_en,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] icount
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_STEP = 2'd2
  } state_t;

  localparam logic [2:0] OP_HALT    = 3'b000;
  localparam logic [2:0] OP_RUN     = 3'b001;
  localparam logic [2:0] OP_STEP    = 3'b010;
  localparam logic [2:0] OP_SET_BP  = 3'b011;
  localparam logic [2:0] OP_CLR_BP  = 3'b100;
  localparam logic [2:0] OP_CLR_CNT = 3'b101;

  localparam state_t RESET_STATE = RUN_ON_RESET ? S_RUN : S_HALT;

  state_t           r_state;
  logic [31:0]      r_bp_addr;
  logic             r_bp_valid;
  logic             r_skip_bp;
  logic             r_halted;
  logic             r_bp_hit;
  logic [CNT_W-1:0] r_icount;

  logic w_pc_eq_bp;
  logic w_bp_match;
  logic w_cpu_en;
  logic w_accept;

  assign w_pc_eq_bp = r_bp_valid && (pc == r_bp_addr);
  assign w_bp_match = w_pc_eq_bp && !r_skip_bp;
  assign w_cpu_en   = (r_state == S_STEP) || ((r_state == S_RUN) && !w_bp_match);
  assign cmd_ready  = (r_state != S_STEP);
  assign w_accept   = cmd_valid && cmd_ready;

  assign cpu_en = w_cpu_en;
  assign halted = r_halted;
  assign bp_hit = r_bp_hit;
  assign icount = r_icount;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RESET_STATE;
      r_halted   <= !RUN_ON_RESET;
      r_bp_hit   <= 1'b0;
      r_bp_addr  <= 32'd0;
      r_bp_valid <= 1'b0;
      r_skip_bp  <= 1'b0;
      r_icount   <= '0;
    end else begin
      r_bp_hit <= 1'b0;

      // Set after the skip clear below so a RUN from HALT can arm it;
      // cpu_en is low in HALT, so the two never collide.
      if (w_cpu_en) r_skip_bp <= 1'b0;

      unique case (r_state)
        S_RUN: begin
          // A breakpoint stop wins; a RUN/STEP accepted alongside it is dropped.
          if (w_bp_match) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
            r_bp_hit <= 1'b1;
          end else if (w_accept && (cmd_op == OP_HALT || cmd_op == OP_STEP)) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
        end
        S_HALT: begin
          if (w_accept && cmd_op == OP_RUN) begin
            r_state   <= S_RUN;
            r_halted  <= 1'b0;
            r_skip_bp <= w_pc_eq_bp;
          end else if (w_accept && cmd_op == OP_STEP) begin
            r_state  <= S_STEP;
            r_halted <= 1'b0;
          end
        end
        S_STEP: begin
          r_state  <= S_HALT;
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= RESET_STATE;
          r_halted <= !RUN_ON_RESET;
        end
      endcase

      if (w_accept && cmd_op == OP_SET_BP) begin
        r_bp_addr  <= cmd_data;
        r_bp_valid <= 1'b1;
      end else if (w_accept && cmd_op == OP_CLR_BP) begin
        r_bp_valid <= 1'b0;
      end

      if (w_accept && cmd_op == OP_CLR_CNT) begin
        r_icount <= '0;
      end else if (w_cpu_en) begin
        r_icount <= r_icount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sm_debug_ctrl.sv
// Directed bench for sm_debug_ctrl: the bench plays the core, advancing pc
// after every edge at which cpu_en was high.
module tb_sm_debug_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;
  logic [31:0] pc;
  logic        cpu_en;
  logic        halted;
  logic        bp_hit;
  logic [31:0] icount;

  logic        rst1;
  logic        c1_valid;
  logic        c1_ready;
  logic [2:0]  c1_op;
  logic [31:0] c1_data;
  logic [31:0] pc1;
  logic        cpu_en1;
  logic        halted1;
  logic        bp_hit1;
  logic [3:0]  icount1;

  int n_chk;
  int n_err;
  logic en_s;

  sm_debug_ctrl #(.RUN_ON_RESET(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .pc(pc), .cpu_en(cpu_en),
    .halted(halted), .bp_hit(bp_hit), .icount(icount)
  );

  sm_debug_ctrl #(.RUN_ON_RESET(1'b0), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst1), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_op(c1_op), .cmd_data(c1_data), .pc(pc1), .cpu_en(cpu_en1),
    .halted(halted1), .bp_hit(bp_hit1), .icount(icount1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample cpu_en before the edge, then act as the core.
  task automatic cyc();
    #1;
    en_s = cpu_en;
    @(posedge clk);
    #1;
    if (en_s) pc = pc + 32'd1;
    cmd_valid = 1'b0;
    c1_valid  = 1'b0;
    #1;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b1; rst1 = 1'b1;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 32'd0; pc = 32'd0;
    c1_valid = 1'b0; c1_op = 3'd0; c1_data = 32'd0; pc1 = 32'd0;
    @(posedge clk); #1;
    chk("rst_halted", halted, 0);
    chk("rst_bp_hit", bp_hit, 0);
    chk("rst_icount", icount, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_halted1", halted1, 1);
    rst = 1'b0;
    #1;
    chk("rel_cpu_en", cpu_en, 1);

    // Free run over ten instructions
    for (int i = 0; i < 10; i++) begin
      chk("run_cpu_en", cpu_en, 1);
      cyc();
    end
    chk("run_icount", icount, 10);
    chk("run_halted", halted, 0);
    chk("run_pc", pc, 10);

    // Asynchronous reset mid-run
    rst = 1'b1;
    #1;
    chk("arst_icount", icount, 0);
    chk("arst_halted", halted, 0);
    pc = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;

    // Breakpoint at 5
    cmd(3'b011, 32'd5);
    cyc();
    for (int k = 0; k < 20 && pc != 32'd5; k++) cyc();
    chk("bp_pc", pc, 5);
    chk("bp_cpu_en_at5", cpu_en, 0);
    chk("bp_pre_halted", halted, 0);
    cyc();
    chk("bp_halted", halted, 1);
    chk("bp_hit_pulse", bp_hit, 1);
    chk("bp_icount", icount, 5);
    chk("bp_cpu_en_halt", cpu_en, 0);
    cyc();
    chk("bp_hit_one", bp_hit, 0);
    chk("bp_still_halted", halted, 1);
    chk("bp_pc_held", pc, 5);

    // Continue past the breakpointed instruction
    cmd(3'b001, 32'd0);
    chk("cont_accept_en", cpu_en, 0);
    cyc();
    chk("cont_halted", halted, 0);
    chk("cont_cpu_en_at5", cpu_en, 1);
    cyc();
    chk("cont_pc", pc, 6);
    chk("cont_cpu_en", cpu_en, 1);
    chk("cont_no_hit", bp_hit, 0);
    chk("cont_icount", icount, 6);

    // HALT, then three single steps
    cmd(3'b000, 32'd0);
    cyc();
    chk("halt_halted", halted, 1);
    chk("halt_icount", icount, 7);
    chk("halt_bp_hit", bp_hit, 0);
    for (int s = 0; s < 3; s++) begin
      cmd(3'b010, 32'd0);
      chk("step_accept_en", cpu_en, 0);
      cyc();
      chk("step_cpu_en", cpu_en, 1);
      chk("step_ready", cmd_ready, 0);
      cyc();
      chk("step_back_en", cpu_en, 0);
      chk("step_back_halted", halted, 1);
    end
    chk("step_icount", icount, 10);
    chk("step_pc", pc, 10);

    // Breakpoint stop beats a RUN accepted in the same cycle
    cmd(3'b011, 32'd12);
    cyc();
    cmd(3'b001, 32'd0);
    cyc();
    cyc();
    cyc();
    chk("pri_pc", pc, 12);
    chk("pri_cpu_en", cpu_en, 0);
    chk("pri_ready", cmd_ready, 1);
    cmd(3'b001, 32'd0);
    cyc();
    chk("pri_halted", halted, 1);
    chk("pri_hit", bp_hit, 1);
    cyc();
    chk("pri_dropped_halted", halted, 1);
    chk("pri_dropped_en", cpu_en, 0);
    chk("pri_hit_clear", bp_hit, 0);
    chk("pri_icount", icount, 12);

    // CLR_BP then RUN: no skip armed, runs freely
    cmd(3'b100, 32'd0);
    cyc();
    cmd(3'b001, 32'd0);
    cyc();
    chk("clrbp_en", cpu_en, 1);
    cyc();
    chk("clrbp_pc", pc, 13);
    chk("clrbp_en2", cpu_en, 1);

    // Halt-on-reset instance with a 4-bit counter
    rst1 = 1'b0;
    #1;
    chk("h_rst_en", cpu_en1, 0);
    chk("h_rst_ready", c1_ready, 1);
    chk("h_rst_halted", halted1, 1);
    c1_valid = 1'b1; c1_op = 3'b001;
    cyc();
    chk("h_run_en", cpu_en1, 1);
    chk("h_run_icount", icount1, 0);
    for (int i = 0; i < 7; i++) cyc();
    chk("h_icount7", icount1, 7);
    c1_valid = 1'b1; c1_op = 3'b101;
    cyc();
    chk("h_clr_mid", icount1, 0);
    for (int i = 0; i < 15; i++) cyc();
    chk("h_icount_max", icount1, 15);
    cyc();
    chk("h_wrap", icount1, 0);
    for (int i = 0; i < 15; i++) cyc();
    chk("h_icount_max2", icount1, 15);
    c1_valid = 1'b1; c1_op = 3'b101;
    chk("h_clr_en", cpu_en1, 1);
    cyc();
    chk("h_clr_max", icount1, 0);
    c1_valid = 1'b1; c1_op = 3'b110;
    cyc();
    chk("h_nop_op", icount1, 1);
    chk("h_nop_halted", halted1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sm_debug_ctrl.md
SM_DEBUG_CTRL -- requirements
Module: sm_debug_ctrl

Interface
REQ-001 SHALL have parameter RUN_ON_RESET, default 1, meaning 1 = core runs after reset and 0 = core halts after reset.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of the executed-instruction counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  debug command present.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-007 SHALL have port cmd_op  input  3  command code: 000 HALT, 001 RUN, 010 STEP, 011 SET_BP, 100 CLR_BP, 101 CLR_CNT; 110 and 111 are accepted with no effect.
REQ-008 SHALL have port cmd_data  input  32  breakpoint word address, used by SET_BP only.
REQ-009 SHALL have port pc  input  32  current core program counter (word address).
REQ-010 SHALL have port cpu_en  output  1  core enable; the core updates pc and the register file only in cycles where cpu_en=1.
REQ-011 SHALL have port halted  output  1  high while the controller is in HALT.
REQ-012 SHALL have port bp_hit  output  1  one-cycle pulse on a breakpoint stop.
REQ-013 SHALL have port icount  output  CNT_W  count of cycles with cpu_en=1.

Function
REQ-014 SHALL implement a state machine with states RUN, HALT and STEP.
REQ-015 SHALL hold internal registers bp_addr[31:0], bp_valid and skip_bp.
REQ-016 SHALL define bp_match = bp_valid & (pc == bp_addr) & ~skip_bp.
REQ-017 SHALL drive cpu_en combinationally as (state==STEP) | (state==RUN & ~bp_match).
REQ-018 SHALL drive cmd_ready = (state != STEP), so commands stall for exactly the one STEP cycle.
REQ-019 SHALL make every accepted command take effect on the next clock edge; in the acceptance cycle, cpu_en still reflects the current state.
REQ-020 RUN with bp_match SHALL go to HALT and register bp_hit=1 for one cycle, coincident with halted rising.
REQ-021 The breakpoint stop SHALL take priority over a RUN or STEP command accepted in the same cycle; such a command is dropped.
REQ-022 HALT, or STEP accepted in RUN, SHALL go to HALT with bp_hit=0.
REQ-023 In HALT, RUN SHALL go to RUN and set skip_bp=1 when bp_valid & (pc == bp_addr), so the breakpointed instruction executes once.
REQ-024 In HALT, STEP SHALL go to STEP, then unconditionally to HALT after one cycle; breakpoints are ignored in STEP.
REQ-025 HALT in HALT and RUN in RUN SHALL have no effect.
REQ-026 SHALL clear skip_bp at the end of any cycle in which cpu_en=1.
REQ-027 SET_BP SHALL load bp_addr=cmd_data and set bp_valid=1; CLR_BP SHALL clear bp_valid; both are legal in any state and apply to the compare from the next cycle.
REQ-028 icount SHALL increment by 1 per cycle with cpu_en=1 and wrap from all-ones to 0.
REQ-029 CLR_CNT SHALL set icount to 0, overriding an increment in the same cycle.
REQ-030 halted SHALL be a registered output equal to (state==HALT).
REQ-031 bp_hit SHALL be a registered output.

Reset
REQ-032 Asserting rst at any time SHALL immediately set state = RUN_ON_RESET ? RUN : HALT, with halted = ~RUN_ON_RESET.
REQ-033 Asserting rst SHALL immediately set bp_valid=0, bp_addr=0, skip_bp=0, bp_hit=0 and icount=0.
REQ-034 After release of rst, cpu_en SHALL be 1 when RUN_ON_RESET=1 and 0 otherwise, and cmd_ready SHALL be 1.
REQ-035 Reset during STEP, or on a breakpoint stop cycle, SHALL discard the pending transition.

Verification
REQ-036 SHALL test RUN_ON_RESET=1, reset released, pc advancing 0,1,2,... for 10 cycles -> cpu_en=1 throughout, icount=10, halted=0.
REQ-037 SHALL test SET_BP 0x5 while running from pc=0 -> cpu_en=0 in the cycle pc=5, then halted=1 and bp_hit=1 for exactly one cycle, and icount=5.
REQ-038 SHALL test continuing from that stop with pc=5: RUN -> the instruction at 5 executes (cpu_en=1 for one cycle with pc=5), with no second stop at pc=5.
REQ-039 SHALL test STEP issued three times from HALT -> exactly three single cpu_en pulses, cmd_ready=0 during each pulse, and icount increments by 3.
REQ-040 SHALL test, in RUN with pc==bp_addr, an accepted RUN in the same cycle -> HALT with bp_hit=1, and the command dropped.
REQ-041 SHALL test CLR_CNT accepted while cpu_en=1 with icount=0xFFFFFFFF -> icount=0 next cycle; separately, without CLR_CNT, icount wraps from 0xFFFFFFFF to 0.
